// File: rtl/if_fetch_addr_gen.sv
// if_fetch_addr_gen: fetch PC owner, req/gnt issue, response FIFO to decode.
// Define IF_FETCH_PERF_EN to add stall/discard performance counters.
module if_fetch_addr_gen #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [AW-1:0] boot_addr_i,
  input  logic          pc_set_i,
  input  logic [AW-1:0] pc_addr_i,
  output logic          instr_req_o,
  output logic [AW-1:0] instr_addr_o,
  input  logic          instr_gnt_i,
  input  logic          instr_rvalid_i,
  input  logic [DW-1:0] instr_rdata_i,
  output logic          fetch_valid_o,
  input  logic          fetch_ready_i,
  output logic [AW-1:0] fetch_addr_o,
  output logic [DW-1:0] fetch_rdata_o,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0]   perf_stall_cnt_o,
  output logic [31:0]   perf_discard_cnt_o,
`endif
  output logic          busy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] INC = AW'(DW / 8);

  typedef enum logic [1:0] {BOOT, IDLE, FETCH} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic [PW-1:0] aq_wr_q, aq_rd_q;
  logic [PW-1:0] f_wr_q, f_rd_q;
  logic [AW-1:0] aq_q [DEPTH];
  logic [AW-1:0] fa_q [DEPTH];
  logic [DW-1:0] fd_q [DEPTH];

  logic [CW:0] cnt;
  logic        redir, rv, drop, req, gnt, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign cnt   = (CW+1)'(outst_q) + (CW+1)'(fcnt_q);
  assign redir = pc_set_i && (state_q != BOOT);
  assign rv    = instr_rvalid_i && (outst_q != '0);
  assign drop  = rv && (disc_q != '0);
  // pend_q keeps an ungranted request alive even after en_i drops
  assign req   = !rst_i && (state_q == FETCH)
               && (cnt < (CW+1)'(DEPTH)) && (en_i || pend_q);
  assign gnt   = req && instr_gnt_i;
  assign push  = rv && !drop && !redir;
  assign pop   = fetch_valid_o && fetch_ready_i && !redir;

  assign instr_req_o   = req;
  assign instr_addr_o  = rst_i ? '0 : pc_q;
  assign fetch_valid_o = !rst_i && (fcnt_q != '0);
  assign fetch_addr_o  = fetch_valid_o ? fa_q[f_rd_q] : '0;
  assign fetch_rdata_o = fetch_valid_o ? fd_q[f_rd_q] : '0;
  assign busy_o = !rst_i && ((outst_q != '0) || (fcnt_q != '0));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    disc_d  = disc_q;
    fcnt_d  = fcnt_q;
    pend_d  = req && !instr_gnt_i;
    unique case (state_q)
      BOOT: begin
        pc_d    = boot_addr_i;
        state_d = IDLE;
      end
      IDLE:    if (en_i) state_d = FETCH;
      FETCH:   if (!en_i && !pend_d) state_d = IDLE;
      default: state_d = BOOT;
    endcase
    if (redir)    pc_d = pc_addr_i;
    else if (gnt) pc_d = pc_q + INC;
    if (gnt && !rv)      outst_d = outst_q + CW'(1);
    else if (!gnt && rv) outst_d = outst_q - CW'(1);
    if (drop)  disc_d = disc_q - CW'(1);
    // everything still in flight after a redirect belongs to the old path
    if (redir) disc_d = outst_d;
    if (redir)             fcnt_d = '0;
    else if (push && !pop) fcnt_d = fcnt_q + CW'(1);
    else if (!push && pop) fcnt_d = fcnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= '0;
      outst_q <= '0;
      disc_q  <= '0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      f_wr_q  <= '0;
      f_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      if (gnt) aq_wr_q <= nxt(aq_wr_q);
      if (rv)  aq_rd_q <= nxt(aq_rd_q);
      if (redir) begin
        f_wr_q <= '0;
        f_rd_q <= '0;
      end else begin
        if (push) f_wr_q <= nxt(f_wr_q);
        if (pop)  f_rd_q <= nxt(f_rd_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) aq_q[aq_wr_q] <= pc_q;
    if (push) begin
      fa_q[f_wr_q] <= aq_q[aq_rd_q];
      fd_q[f_wr_q] <= instr_rdata_i;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] stall_q, dcnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      dcnt_q  <= '0;
    end else begin
      if (req && !instr_gnt_i && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (rv && (drop || redir) && (dcnt_q != '1))
        dcnt_q <= dcnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o   = rst_i ? '0 : stall_q;
  assign perf_discard_cnt_o = rst_i ? '0 : dcnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_addr_gen.sv
// Directed bench for if_fetch_addr_gen with a one-cycle-latency memory.
// Define IF_FETCH_PERF_EN to also check the perf counters.
module tb_if_fetch_addr_gen;

  localparam logic [31:0] MASK = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_i, en_i, pc_set_i;
  logic [31:0] boot_addr_i, pc_addr_i;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        fetch_valid_o, fetch_ready_i, busy_o;
  logic [31:0] fetch_addr_o, fetch_rdata_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt_o, perf_discard_cnt_o;
`endif

  logic        gnt_en, resp_en;
  logic [31:0] rq[$];
  logic [31:0] granted[$];
  logic [31:0] acc_a[$];
  logic [31:0] acc_d[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  if_fetch_addr_gen #(.AW(32), .DW(32), .DEPTH(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .boot_addr_i    (boot_addr_i),
    .pc_set_i       (pc_set_i),
    .pc_addr_i      (pc_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_rdata_o  (fetch_rdata_o),
`ifdef IF_FETCH_PERF_EN
    .perf_stall_cnt_o   (perf_stall_cnt_o),
    .perf_discard_cnt_o (perf_discard_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  // memory: grants when enabled, answers in order one cycle later
  always @(negedge clk) begin
    #2;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    if (resp_en && rq.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = rq.pop_front() ^ MASK;
    end
    instr_gnt_i = gnt_en && instr_req_o;
    if (gnt_en && instr_req_o) begin
      rq.push_back(instr_addr_o);
      granted.push_back(instr_addr_o);
    end
    if (fetch_valid_o && fetch_ready_i) begin
      acc_a.push_back(fetch_addr_o);
      acc_d.push_back(fetch_rdata_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] boot);
    rst_i = 1'b1; en_i = 1'b0; pc_set_i = 1'b0;
    gnt_en = 1'b0; resp_en = 1'b0; fetch_ready_i = 1'b0;
    boot_addr_i = boot;
    tick(2);
    rst_i = 1'b0;
    granted.delete(); acc_a.delete(); acc_d.delete();
  endtask

  task automatic wait_gnt(input int n, input string tag);
    int i = 0;
    do begin tick(1); #1; i++; end
    while (granted.size() < n && i < 60);
    chk(tag, 32'(granted.size() >= n), 32'd1);
  endtask

  task automatic wait_acc(input int n, input string tag);
    int i = 0;
    do begin tick(1); #1; i++; end
    while (acc_a.size() < n && i < 60);
    chk(tag, 32'(acc_a.size() >= n), 32'd1);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    en_i = 1'b0; gnt_en = 1'b1; resp_en = 1'b1; fetch_ready_i = 1'b1;
    do begin tick(1); #1; i++; end
    while (busy_o && i < 60);
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; pc_set_i = 1'b0; pc_addr_i = '0;
    boot_addr_i = '0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    instr_rdata_i = '0; fetch_ready_i = 1'b0;
    gnt_en = 1'b0; resp_en = 1'b0;

    tick(1); #1;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    do_reset(32'h80);
    en_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; fetch_ready_i = 1'b1;
    wait_acc(3, "boot_wait");
    chk("boot_a0", acc_a[0], 32'h80);
    chk("boot_a1", acc_a[1], 32'h84);
    chk("boot_a2", acc_a[2], 32'h88);
    chk("boot_d0", acc_d[0], 32'h80 ^ MASK);
    chk("boot_d2", acc_d[2], 32'h88 ^ MASK);
    drain("boot_drain");

    do_reset(32'h80);
    en_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1;
    tick(12); #1;
    chk("bp_ngnt", 32'(granted.size()), 32'd2);
    chk("bp_req", 32'(instr_req_o), 32'd0);
    chk("bp_valid", 32'(fetch_valid_o), 32'd1);
    chk("bp_addr", fetch_addr_o, 32'h80);
    chk("bp_data", fetch_rdata_o, 32'h80 ^ MASK);
    tick(1);
    fetch_ready_i = 1'b1;
    wait_gnt(3, "bp_wait");
    chk("bp_next", granted[2], 32'h88);
    drain("bp_drain");
    chk("bp_acc1", acc_a[1], 32'h84);

    do_reset(32'h100);
    en_i = 1'b1; gnt_en = 1'b1;
    wait_gnt(2, "rd_wait");
    tick(2); #1;
    chk("rd_hold", 32'(instr_req_o), 32'd0);
    chk("rd_old1", granted[1], 32'h104);
    tick(1);
    pc_set_i = 1'b1; pc_addr_i = 32'h2000;
    tick(1);
    pc_set_i = 1'b0; resp_en = 1'b1; fetch_ready_i = 1'b1;
    wait_acc(1, "rd_wait2");
    chk("rd_first", acc_a[0], 32'h2000);
    chk("rd_data", acc_d[0], 32'h2000 ^ MASK);
    chk("rd_newreq", granted[2], 32'h2000);
    drain("rd_drain");
`ifdef IF_FETCH_PERF_EN
    chk("rd_perf", perf_discard_cnt_o, 32'd2);
`endif

    do_reset(32'h80);
    en_i = 1'b1; resp_en = 1'b1; fetch_ready_i = 1'b1;
    begin
      int i = 0;
      do begin tick(1); #1; i++; end
      while (!instr_req_o && i < 20);
    end
    chk("sg_req", 32'(instr_req_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("sg_addr", instr_addr_o, 32'h80);
      tick(1); #1;
    end
    gnt_en = 1'b1; en_i = 1'b0;
    drain("sg_drain");
    chk("sg_ngnt", 32'(granted.size()), 32'd1);
    chk("sg_gaddr", granted[0], 32'h80);
`ifdef IF_FETCH_PERF_EN
    chk("sg_perf", perf_stall_cnt_o, 32'd5);
`endif

    do_reset(32'h0);
    tick(1);
    pc_set_i = 1'b1; pc_addr_i = 32'hFFFF_FFFC;
    tick(1);
    pc_set_i = 1'b0; #1;
    chk("wr_idle_pc", instr_addr_o, 32'hFFFF_FFFC);
    en_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; fetch_ready_i = 1'b1;
    wait_gnt(2, "wr_wait");
    chk("wr_a0", granted[0], 32'hFFFF_FFFC);
    chk("wr_a1", granted[1], 32'h0);
    drain("wr_drain");

    do_reset(32'h300);
    en_i = 1'b1; gnt_en = 1'b1; fetch_ready_i = 1'b1;
    wait_gnt(1, "mf_wait");
    en_i = 1'b0;
    tick(1); #1;
    chk("mf_busy", 32'(busy_o), 32'd1);
    chk("mf_one", 32'(granted.size()), 32'd1);
    tick(1);
    rst_i = 1'b1; boot_addr_i = 32'h400; #1;
    chk("mf_rbusy", 32'(busy_o), 32'd0);
    chk("mf_rvalid", 32'(fetch_valid_o), 32'd0);
    tick(2);
    rst_i = 1'b0; resp_en = 1'b1;
    tick(3); #1;
    chk("mf_late_v", 32'(fetch_valid_o), 32'd0);
    chk("mf_late_b", 32'(busy_o), 32'd0);
    chk("mf_boot", instr_addr_o, 32'h400);
    granted.delete();
    en_i = 1'b1;
    wait_gnt(1, "mf_wait2");
    chk("mf_g0", granted[0], 32'h400);
    drain("mf_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
